// File: rtl/ecc_op_sequencer.sv
// Control FSM for one ECC operation: encode, decode, or full channel (encode, noise, decode).
// Issues engine start pulses, waits for done under a timeout, and reports sticky status.
module ecc_op_sequencer #(
   parameter int AMBA_WORD = 32,
   parameter int TIMEOUT   = 64,
   parameter int CNT_W     = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_op_req,
   input  logic [1:0]           i_op_code,
   input  logic [1:0]           i_cw_sel,
   input  logic                 i_abort,
   input  logic                 i_enc_done,
   input  logic                 i_dec_done,
   output logic                 o_enc_start,
   output logic                 o_dec_start,
   output logic                 o_noise_en,
   output logic                 o_dec_src_sel,
   output logic [1:0]           o_width_sel,
   output logic                 o_busy,
   output logic                 o_op_done,
   output logic [AMBA_WORD-1:0] o_status,
   output logic [2:0]           o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ENC_GO   = 3'd1,
      S_ENC_WAIT = 3'd2,
      S_NOISE    = 3'd3,
      S_DEC_GO   = 3'd4,
      S_DEC_WAIT = 3'd5,
      S_FINISH   = 3'd6,
      S_FAIL     = 3'd7
   } state_t;

   localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             r_full;
   logic             r_enc_start;
   logic             r_dec_start;
   logic             r_noise_en;
   logic             r_dec_src_sel;
   logic [1:0]       r_width_sel;
   logic             r_busy;
   logic             r_op_done;
   logic             r_ovr;
   logic             r_tmo;
   logic             r_rej;
   logic             r_err;
   logic             w_accept;
   logic             w_reject;
   logic             w_tmo;
   logic             w_active;
   logic             w_abort;

   // Abort only cancels states where an operation is still in flight.
   assign w_active = (r_state != S_IDLE) && (r_state != S_FINISH) && (r_state != S_FAIL);
   assign w_abort  = i_abort && w_active;

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_reject = 1'b0;
      w_tmo    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_op_req) begin
               if ((i_op_code == 2'b11) || (i_cw_sel == 2'b11)) begin
                  w_next   = S_FAIL;
                  w_reject = 1'b1;
               end else begin
                  w_accept = 1'b1;
                  w_next   = (i_op_code == 2'b01) ? S_DEC_GO : S_ENC_GO;
               end
            end
         end
         S_ENC_GO: w_next = S_ENC_WAIT;
         S_ENC_WAIT: begin
            // Done takes priority over expiry in the same cycle.
            if (i_enc_done) begin
               w_next = r_full ? S_NOISE : S_FINISH;
            end else if (r_cnt <= LP_ONE) begin
               w_next = S_FAIL;
               w_tmo  = 1'b1;
            end
         end
         S_NOISE:  w_next = S_DEC_GO;
         S_DEC_GO: w_next = S_DEC_WAIT;
         S_DEC_WAIT: begin
            if (i_dec_done) begin
               w_next = S_FINISH;
            end else if (r_cnt <= LP_ONE) begin
               w_next = S_FAIL;
               w_tmo  = 1'b1;
            end
         end
         S_FINISH: w_next = S_IDLE;
         S_FAIL:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
      if (w_abort) begin
         w_next = S_IDLE;
         w_tmo  = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_full        <= 1'b0;
         r_enc_start   <= 1'b0;
         r_dec_start   <= 1'b0;
         r_noise_en    <= 1'b0;
         r_dec_src_sel <= 1'b0;
         r_width_sel   <= 2'b00;
         r_busy        <= 1'b0;
         r_op_done     <= 1'b0;
         r_ovr         <= 1'b0;
         r_tmo         <= 1'b0;
         r_rej         <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_enc_start <= (w_next == S_ENC_GO);
         r_dec_start <= (w_next == S_DEC_GO);
         r_noise_en  <= (w_next == S_NOISE);
         r_busy      <= (w_next != S_IDLE);
         r_op_done   <= (w_next == S_FINISH) || (w_next == S_FAIL);

         // The wait count equals TIMEOUT cycles spent in the WAIT state.
         if ((r_state == S_ENC_GO) || (r_state == S_DEC_GO)) begin
            r_cnt <= LP_TIMEOUT;
         end else if ((r_state == S_ENC_WAIT) || (r_state == S_DEC_WAIT)) begin
            r_cnt <= r_cnt - LP_ONE;
         end

         if (w_accept) begin
            r_width_sel   <= i_cw_sel;
            r_full        <= (i_op_code == 2'b10);
            r_dec_src_sel <= (i_op_code == 2'b10);
            r_ovr         <= 1'b0;
            r_tmo         <= 1'b0;
            r_rej         <= 1'b0;
            r_err         <= 1'b0;
         end
         if (i_op_req && (r_state != S_IDLE)) begin
            r_ovr <= 1'b1;
         end
         if (w_reject) begin
            r_rej <= 1'b1;
         end
         if (w_tmo) begin
            r_tmo <= 1'b1;
         end
         if ((w_next == S_FAIL) || w_abort) begin
            r_err <= 1'b1;
         end
      end
   end

   assign o_enc_start   = r_enc_start;
   assign o_dec_start   = r_dec_start;
   assign o_noise_en    = r_noise_en;
   assign o_dec_src_sel = r_dec_src_sel;
   assign o_width_sel   = r_width_sel;
   assign o_busy        = r_busy;
   assign o_op_done     = r_op_done;
   assign o_status      = {{(AMBA_WORD-4){1'b0}}, r_ovr, r_tmo, r_rej, r_err};
   assign o_dbg_state   = r_state;

endmodule
